// File: rtl/program_scheduler.sv
// Round-robin multiprogramming scheduler: keeps a PC per program slot, counts an
// instruction quantum and drives the CPU PC reload when the running program is switched.
module program_scheduler #(
  parameter int N_PROG          = 4,
  parameter int PC_W            = 32,
  parameter int Q_W             = 16,
  parameter int DEFAULT_QUANTUM = 100,
  localparam int ID_W           = $clog2(N_PROG)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              base_we,
  input  logic [ID_W-1:0]   base_idx,
  input  logic [PC_W-1:0]   base_pc,
  input  logic              quantum_we,
  input  logic [Q_W-1:0]    quantum_in,
  input  logic              instr_step,
  input  logic [PC_W-1:0]   pc_now,
  input  logic              yield,
  input  logic              end_prog,
  output logic              hold,
  output logic              pc_load_en,
  output logic [PC_W-1:0]   pc_load_val,
  output logic              change_program,
  output logic [ID_W-1:0]   cur_prog,
  output logic [N_PROG-1:0] active_mask,
  output logic [Q_W-1:0]    quantum_left,
  output logic              all_done,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    LOAD   = 3'd2,
    RUN    = 3'd3,
    SAVE   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   tab [N_PROG];
  logic [Q_W-1:0]    quantum_reg;
  logic [ID_W-1:0]   sel;
  logic              first_pick;
  logic              found;
  logic [ID_W-1:0]   found_idx;
  logic              base_ok;

  assign state_dbg = state;
  assign base_ok   = base_we && (int'(base_idx) < N_PROG);

  // Search order starts after cur_prog and wraps, cur_prog itself last; the very first
  // pick after start behaves as if slot N_PROG-1 had been running, so slot 0 comes first.
  always_comb begin
    int base_i;
    int j;
    logic [ID_W-1:0] jj;
    found     = 1'b0;
    found_idx = '0;
    base_i    = first_pick ? N_PROG - 1 : int'(cur_prog);
    j         = 0;
    jj        = '0;
    for (int k = N_PROG; k >= 1; k--) begin
      j = base_i + k;
      if (j >= N_PROG) j = j - N_PROG;
      jj = ID_W'(j);
      if (active_mask[jj]) begin
        found     = 1'b1;
        found_idx = jj;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      for (int i = 0; i < N_PROG; i++) tab[i] <= '0;
      quantum_reg    <= Q_W'(DEFAULT_QUANTUM);
      quantum_left   <= '0;
      sel            <= '0;
      cur_prog       <= '0;
      first_pick     <= 1'b0;
      active_mask    <= '0;
      hold           <= 1'b0;
      pc_load_en     <= 1'b0;
      pc_load_val    <= '0;
      change_program <= 1'b0;
      all_done       <= 1'b0;
    end else begin
      pc_load_en     <= 1'b0;
      change_program <= 1'b0;
      case (state)
        IDLE: begin
          if (start && |active_mask) begin
            state      <= SELECT;
            hold       <= 1'b1;
            first_pick <= 1'b1;
          end
        end
        SELECT: begin
          first_pick <= 1'b0;
          if (found) begin
            state          <= LOAD;
            sel            <= found_idx;
            pc_load_en     <= 1'b1;
            change_program <= 1'b1;
            pc_load_val    <= tab[found_idx];
          end else begin
            state    <= DONE;
            hold     <= 1'b0;
            all_done <= 1'b1;
          end
        end
        LOAD: begin
          cur_prog     <= sel;
          quantum_left <= quantum_reg;
          state        <= RUN;
          hold         <= 1'b0;
        end
        RUN: begin
          if (instr_step && quantum_left != '0) quantum_left <= quantum_left - 1'b1;
          // A zero quantum never reaches 1, so preemption is disabled without a separate flag.
          if (end_prog) begin
            active_mask[cur_prog] <= 1'b0;
            state                 <= SELECT;
            hold                  <= 1'b1;
          end else if (yield || (instr_step && quantum_left == Q_W'(1))) begin
            state <= SAVE;
            hold  <= 1'b1;
          end
        end
        SAVE: begin
          tab[cur_prog] <= pc_now;
          state         <= SELECT;
        end
        DONE: begin
          if (base_ok) begin
            state    <= IDLE;
            all_done <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          hold  <= 1'b0;
        end
      endcase
      if (quantum_we) quantum_reg <= quantum_in;
      // Placed last so a same-cycle slot write beats both the SAVE and the end_prog clear.
      if (base_ok) begin
        tab[base_idx]         <= base_pc;
        active_mask[base_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_scheduler.sv
// Bench for program_scheduler: table of scheduling actions with expected switch results,
// plus hand-written sequences for reset, quantum change, DONE exit and reset mid-switch.
module tb_program_scheduler;

  localparam int N_PROG = 4;
  localparam int PC_W   = 32;
  localparam int Q_W    = 16;
  localparam int ID_W   = 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_SAVE = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam int K_RST   = 0;
  localparam int K_BASE  = 1;
  localparam int K_START = 2;
  localparam int K_YIELD = 3;
  localparam int K_EXP   = 4;
  localparam int K_END   = 5;

  logic              clock;
  logic              reset;
  logic              start;
  logic              base_we;
  logic [ID_W-1:0]   base_idx;
  logic [PC_W-1:0]   base_pc;
  logic              quantum_we;
  logic [Q_W-1:0]    quantum_in;
  logic              instr_step;
  logic [PC_W-1:0]   pc_now;
  logic              yield;
  logic              end_prog;
  logic              hold;
  logic              pc_load_en;
  logic [PC_W-1:0]   pc_load_val;
  logic              change_program;
  logic [ID_W-1:0]   cur_prog;
  logic [N_PROG-1:0] active_mask;
  logic [Q_W-1:0]    quantum_left;
  logic              all_done;
  logic [2:0]        state_dbg;

  program_scheduler #(
    .N_PROG(N_PROG), .PC_W(PC_W), .Q_W(Q_W), .DEFAULT_QUANTUM(100)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .base_we(base_we), .base_idx(base_idx),
    .base_pc(base_pc), .quantum_we(quantum_we), .quantum_in(quantum_in),
    .instr_step(instr_step), .pc_now(pc_now), .yield(yield), .end_prog(end_prog),
    .hold(hold), .pc_load_en(pc_load_en), .pc_load_val(pc_load_val),
    .change_program(change_program), .cur_prog(cur_prog), .active_mask(active_mask),
    .quantum_left(quantum_left), .all_done(all_done), .state_dbg(state_dbg)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int load_count = 0;
  logic [PC_W-1:0] exp_q[$];

  typedef struct {
    int          kind;
    int          arg;
    logic [31:0] pc;
    logic [31:0] exp_pc;
    int          exp_slot;
    int          exp_lat;
    int          exp_ql;
    logic [3:0]  exp_mask;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // scoreboard: every reload strobe must match the next expected PC
  always @(negedge clock) begin
    if (!reset && (pc_load_en || change_program)) begin
      check("change_program_vs_pc_load_en", 64'(change_program), 64'(pc_load_en));
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_load: got pc 0x%0h, expected no reload", pc_load_val);
      end else begin
        check("pc_load_val", 64'(pc_load_val), 64'(exp_q.pop_front()));
      end
      load_count++;
    end
  end

  // driver tasks
  task automatic apply_reset();
    reset = 1'b1; start = 1'b0; base_we = 1'b0; base_idx = '0; base_pc = '0;
    quantum_we = 1'b0; quantum_in = '0; instr_step = 1'b0; pc_now = '0;
    yield = 1'b0; end_prog = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic load_slot(input int idx, input logic [31:0] pc);
    base_we = 1'b1; base_idx = ID_W'(idx); base_pc = pc;
    tick();
    base_we = 1'b0;
  endtask

  task automatic set_q(input int q);
    quantum_we = 1'b1; quantum_in = Q_W'(q);
    tick();
    quantum_we = 1'b0;
  endtask

  task automatic wait_load(input string name, input int exp_lat);
    int lat;
    lat = 1;
    while (!pc_load_en && lat < 40) begin
      tick();
      lat++;
    end
    check(name, 64'(lat), 64'(exp_lat));
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", i);
    case (v.kind)
      K_RST: begin
        apply_reset();
        set_q(v.arg);
      end
      K_BASE: load_slot(v.arg, v.pc);
      default: begin
        exp_q.push_back(v.exp_pc);
        pc_now = v.pc;
        if (v.kind == K_START) begin
          start = 1'b1; tick(); start = 1'b0;
        end else if (v.kind == K_YIELD) begin
          yield = 1'b1; tick(); yield = 1'b0;
        end else if (v.kind == K_EXP) begin
          instr_step = 1'b1;
          repeat (v.arg) tick();
          instr_step = 1'b0;
        end else begin
          instr_step = 1'b1;
          repeat (v.arg - 1) tick();
          end_prog = 1'b1; tick(); end_prog = 1'b0;
          instr_step = 1'b0;
        end
        wait_load({tag, "_latency"}, v.exp_lat);
        tick();
        check({tag, "_cur_prog"}, 64'(cur_prog), 64'(v.exp_slot));
        check({tag, "_quantum_left"}, 64'(quantum_left), 64'(v.exp_ql));
        check({tag, "_active_mask"}, 64'(active_mask), 64'(v.exp_mask));
        check({tag, "_hold"}, 64'(hold), 64'd0);
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    int lc;
    // kind, arg, pc_now, exp_pc, exp_slot, exp_lat, exp_ql, exp_mask
    vecs[0]  = '{K_RST,   3, 32'h0,   32'h0,   0, 0, 0, 4'b0000};
    vecs[1]  = '{K_BASE,  0, 32'h000, 32'h0,   0, 0, 0, 4'b0000};
    vecs[2]  = '{K_BASE,  1, 32'h100, 32'h0,   0, 0, 0, 4'b0000};
    vecs[3]  = '{K_START, 0, 32'h0,   32'h000, 0, 2, 3, 4'b0011};
    vecs[4]  = '{K_EXP,   3, 32'h003, 32'h100, 1, 3, 3, 4'b0011};
    vecs[5]  = '{K_EXP,   3, 32'h103, 32'h003, 0, 3, 3, 4'b0011};
    vecs[6]  = '{K_YIELD, 0, 32'h004, 32'h103, 1, 3, 3, 4'b0011};
    vecs[7]  = '{K_RST,   2, 32'h0,   32'h0,   0, 0, 0, 4'b0000};
    vecs[8]  = '{K_BASE,  0, 32'h000, 32'h0,   0, 0, 0, 4'b0000};
    vecs[9]  = '{K_BASE,  2, 32'h200, 32'h0,   0, 0, 0, 4'b0000};
    vecs[10] = '{K_START, 0, 32'h0,   32'h000, 0, 2, 2, 4'b0101};
    vecs[11] = '{K_EXP,   2, 32'h010, 32'h200, 2, 3, 2, 4'b0101};
    vecs[12] = '{K_EXP,   2, 32'h210, 32'h010, 0, 3, 2, 4'b0101};
    vecs[13] = '{K_YIELD, 0, 32'h011, 32'h210, 2, 3, 2, 4'b0101};
    vecs[14] = '{K_EXP,   2, 32'h211, 32'h011, 0, 3, 2, 4'b0101};
    vecs[15] = '{K_END,   2, 32'h012, 32'h211, 2, 2, 2, 4'b0100};

    // reset values and default quantum
    apply_reset();
    check("rst_hold", 64'(hold), 64'd0);
    check("rst_pc_load_en", 64'(pc_load_en), 64'd0);
    check("rst_change_program", 64'(change_program), 64'd0);
    check("rst_pc_load_val", 64'(pc_load_val), 64'd0);
    check("rst_cur_prog", 64'(cur_prog), 64'd0);
    check("rst_active_mask", 64'(active_mask), 64'd0);
    check("rst_quantum_left", 64'(quantum_left), 64'd0);
    check("rst_all_done", 64'(all_done), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(S_IDLE));
    load_slot(3, 32'h300);
    exp_q.push_back(32'h300);
    start = 1'b1; tick(); start = 1'b0;
    wait_load("default_q_latency", 2);
    tick();
    check("default_quantum", 64'(quantum_left), 64'd100);
    check("default_cur_prog", 64'(cur_prog), 64'd3);
    end_prog = 1'b1; tick(); end_prog = 1'b0;
    tick();
    check("done_all_done", 64'(all_done), 64'd1);
    check("done_hold", 64'(hold), 64'd0);
    check("done_state", 64'(state_dbg), 64'(S_DONE));
    load_slot(1, 32'h100);
    check("done_exit_state", 64'(state_dbg), 64'(S_IDLE));
    check("done_exit_all_done", 64'(all_done), 64'd0);
    check("done_exit_mask", 64'(active_mask), 64'b0010);

    // rotation, skipping empty slot, end_prog beating expiry
    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // last running slot ends -> DONE
    end_prog = 1'b1; tick(); end_prog = 1'b0;
    tick();
    check("last_end_all_done", 64'(all_done), 64'd1);
    check("last_end_hold", 64'(hold), 64'd0);
    check("last_end_mask", 64'(active_mask), 64'd0);

    // quantum set to 0 mid-slice: current slice still expires, next never preempts
    apply_reset();
    set_q(4);
    load_slot(0, 32'h000);
    load_slot(1, 32'h100);
    exp_q.push_back(32'h000);
    start = 1'b1; tick(); start = 1'b0;
    wait_load("q0_start_latency", 2);
    tick();
    pc_now = 32'h004;
    instr_step = 1'b1;
    tick();
    quantum_we = 1'b1; quantum_in = '0;
    tick();
    quantum_we = 1'b0;
    tick();
    exp_q.push_back(32'h100);
    tick();
    instr_step = 1'b0;
    wait_load("q0_expiry_latency", 3);
    tick();
    check("q0_cur_prog", 64'(cur_prog), 64'd1);
    check("q0_quantum_left", 64'(quantum_left), 64'd0);
    lc = load_count;
    instr_step = 1'b1;
    for (int s = 0; s < 500; s++) begin
      pc_now = 32'h100 + 32'($urandom_range(0, 255));
      tick();
    end
    instr_step = 1'b0;
    check("q0_no_switch", 64'(load_count), 64'(lc));
    check("q0_still_run", 64'(state_dbg), 64'(S_RUN));
    exp_q.push_back(32'h004);
    pc_now = 32'h1F4;
    yield = 1'b1; tick(); yield = 1'b0;
    wait_load("q0_yield_latency", 3);
    tick();
    check("q0_yield_cur_prog", 64'(cur_prog), 64'd0);

    // reset while in SAVE
    pc_now = 32'h005;
    yield = 1'b1; tick(); yield = 1'b0;
    check("save_state", 64'(state_dbg), 64'(S_SAVE));
    check("save_hold", 64'(hold), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("midrst_state", 64'(state_dbg), 64'(S_IDLE));
    check("midrst_mask", 64'(active_mask), 64'd0);
    check("midrst_hold", 64'(hold), 64'd0);
    check("midrst_pc_load_en", 64'(pc_load_en), 64'd0);
    lc = load_count;
    start = 1'b1;
    repeat (5) tick();
    start = 1'b0;
    check("midrst_no_load", 64'(load_count), 64'(lc));
    check("midrst_idle_no_slots", 64'(state_dbg), 64'(S_IDLE));
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
